// File: rtl/rmio_rf_seq.sv
// RF-side sequencer for the RF-RAM <-> execution-unit port: loads EU input slots
// from RAM, waits for the EU, then writes EU result slots back to RAM.
module rmio_rf_seq #(
  parameter int                INPUT_NUM   = 1,
  parameter int                OUTPUT_NUM  = 1,
  parameter int                DATA_W      = 1408,
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] INPUT_ADDR  = '0,
  parameter logic [ADDR_W-1:0] OUTPUT_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         eu_done,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [DATA_W-1:0]            ram_wdata,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic [INPUT_NUM*DATA_W-1:0]  input_data,
  output logic [INPUT_NUM-1:0]         input_we,
  output logic [OUTPUT_NUM-1:0]        output_re,
  input  logic [OUTPUT_NUM*DATA_W-1:0] output_data
);

  localparam int IW = (INPUT_NUM  > 1) ? $clog2(INPUT_NUM)  : 1;
  localparam int OW = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;

  // WAIT_EU0 is the first wait cycle, in which eu_done is deliberately ignored.
  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WAIT_EU0, WAIT_EU, WB_RE, WB_WR, DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       i_reg;
  logic [OW-1:0]       j_reg;
  logic [DATA_W-1:0]   wb_q_reg;
  logic [DATA_W-1:0]   out_sel;
  logic                i_last, j_last;

  assign i_last = (i_reg == IW'(INPUT_NUM - 1));
  assign j_last = (j_reg == OW'(OUTPUT_NUM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      wb_q_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start)                i_reg <= '0;
      else if (state_reg == RD_DATA && !i_last)      i_reg <= i_reg + IW'(1);
      if (state_reg == WAIT_EU && eu_done)           j_reg <= '0;
      else if (state_reg == WB_WR && !j_last)        j_reg <= j_reg + OW'(1);
      if (state_reg == WB_RE)                        wb_q_reg <= out_sel;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = RD_ADDR;
      RD_ADDR:  state_next = RD_DATA;
      RD_DATA:  state_next = i_last ? WAIT_EU0 : RD_ADDR;
      WAIT_EU0: state_next = WAIT_EU;
      WAIT_EU:  if (eu_done) state_next = WB_RE;
      WB_RE:    state_next = WB_WR;
      WB_WR:    state_next = j_last ? DONE : WB_RE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    out_sel = '0;
    for (int k = 0; k < OUTPUT_NUM; k++)
      if (j_reg == OW'(k)) out_sel = output_data[k*DATA_W +: DATA_W];
  end

  // All port outputs decode from registered state only.
  always_comb begin
    busy      = (state_reg != IDLE);
    done      = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    output_re = '0;
    case (state_reg)
      RD_ADDR: begin
        ram_en   = 1'b1;
        ram_addr = INPUT_ADDR + ADDR_W'(i_reg);
      end
      WB_RE: begin
        for (int k = 0; k < OUTPUT_NUM; k++)
          output_re[k] = (j_reg == OW'(k));
      end
      WB_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = OUTPUT_ADDR + ADDR_W'(j_reg);
        ram_wdata = wb_q_reg;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Input slots are loaded at the end of RD_DATA, so data and strobe appear together.
  for (genvar gi = 0; gi < INPUT_NUM; gi++) begin : g_slot
    logic [DATA_W-1:0] slot_reg;
    logic              we_reg;
    logic              load;

    assign load = (state_reg == RD_DATA) && (i_reg == IW'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= '0;
        we_reg   <= 1'b0;
      end else begin
        we_reg <= load;
        if (load) slot_reg <= ram_rdata;
      end
    end

    assign input_data[gi*DATA_W +: DATA_W] = slot_reg;
    assign input_we[gi]                    = we_reg;
  end

endmodule
